// File: rtl/handshake_listener_if.sv
// Bundle between the four-phase listener and its environment (talker req/data,
// returned ack, consumer valid/ready, status).
interface handshake_listener_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  req_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ack_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_in;
  logic [CNT_WIDTH-1:0]  xfer_count;
  logic                  proto_err;
  logic                  busy;

  modport slave (
    input  req_in, data_in, ready_in,
    output ack_out, data_out, valid_out, xfer_count, proto_err, busy
  );

  modport master (
    output req_in, data_in, ready_in,
    input  ack_out, data_out, valid_out, xfer_count, proto_err, busy
  );
endinterface

// File: rtl/handshake_listener.sv
// Receiving side of a four-phase bundled-data handshake in the clk1 domain:
// req synchronizer, word capture, valid/ready delivery, registered ack.
module handshake_listener #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                clk1,
  input  logic                reset1,
  handshake_listener_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DELIVER, ACK} state_t;

  state_t                  r_state, w_state_n;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    w_req_s;
  logic [DATA_WIDTH-1:0]   r_data, w_data_n;
  logic                    r_valid, w_valid_n;
  logic                    r_ack, w_ack_n;
  logic [CNT_WIDTH-1:0]    r_cnt, w_cnt_n;
  logic                    r_err, w_err_n;

  assign w_req_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      r_sync  <= '0;
      r_state <= IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ack   <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.req_in};
      r_state <= w_state_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_ack   <= w_ack_n;
      r_cnt   <= w_cnt_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_data_n  = r_data;
    w_valid_n = r_valid;
    w_ack_n   = r_ack;
    w_cnt_n   = r_cnt;
    w_err_n   = r_err;
    unique case (r_state)
      IDLE: begin
        // data_in is bundled: it is stable by the time req_s is seen high
        if (w_req_s) begin
          w_data_n  = bus.data_in;
          w_valid_n = 1'b1;
          w_state_n = DELIVER;
        end
      end
      DELIVER: begin
        // Talker withdrew req before ack; flag it but finish the transfer
        if (!w_req_s) w_err_n = 1'b1;
        if (r_valid && bus.ready_in) begin
          w_valid_n = 1'b0;
          w_ack_n   = 1'b1;
          w_state_n = ACK;
        end
      end
      ACK: begin
        if (!w_req_s) begin
          w_ack_n   = 1'b0;
          w_cnt_n   = r_cnt + CNT_WIDTH'(1);
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign bus.ack_out    = r_ack;
  assign bus.data_out   = r_data;
  assign bus.valid_out  = r_valid;
  assign bus.xfer_count = r_cnt;
  assign bus.proto_err  = r_err;
  assign bus.busy       = (r_state != IDLE);

endmodule
